// File: rtl/grid_row_scanner.sv
// grid_row_scanner: frame-buffered row scanner that drives an 8x8 LED matrix from a 64-bit grid.
// Optional macro SCAN_ACTIVE_LOW_EN inverts row_sel/col_data for common-anode matrices.
module grid_row_scanner #(
    parameter int unsigned ROW_HOLD     = 1000,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    input  logic        enable,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned MaxCount = (ROW_HOLD > BLANK_CYCLES) ? ROW_HOLD : BLANK_CYCLES;
    localparam int unsigned CntW     = $clog2(MaxCount + 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(ROW_HOLD - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

`ifdef SCAN_ACTIVE_LOW_EN
    localparam logic [7:0] OutInv = 8'hFF;
`else
    localparam logic [7:0] OutInv = 8'h00;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StShow, StBlank} state_e;

    state_e          state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     shadow_q, shadow_d;
    logic [63:0]     active_q, active_d;
    logic            pending_q, pending_d;
    logic [7:0]      row_sel_q, row_sel_d;
    logic [7:0]      col_data_q, col_data_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;
    logic            lit_d;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;

        if (grid_valid) begin
            shadow_d  = grid_in;
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // A pulse landing in this cycle bypasses the shadow and is shown immediately.
                if (grid_valid) begin
                    active_d  = grid_in;
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end
                row_d   = 3'd0;
                cnt_d   = '0;
                state_d = StShow;
            end
            StShow: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StBlank;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    cnt_d = '0;
                    if (row_q != 3'd7) begin
                        row_d   = row_q + 3'd1;
                        state_d = StShow;
                    end else if (enable) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are derived from next-state values so the registered outputs line up with state_q.
    always_comb begin
        lit_d        = (state_d == StShow);
        row_sel_d    = OutInv ^ (lit_d ? (8'd1 << row_d) : 8'd0);
        col_data_d   = OutInv ^ (lit_d ? active_d[{row_d, 3'b000} +: 8] : 8'd0);
        frame_done_d = (state_d == StBlank) && (row_d == 3'd7) && (cnt_d == BlankLast);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            row_q        <= 3'd0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            row_sel_q    <= OutInv;
            col_data_q   <= OutInv;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
